// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle plus the uart_tx start/busy port.
// master: the environment (debug sources and uart_tx model) driving req_* and tx_busy.
// slave : the arbiter consuming requests and driving tx_start/tx_data.
//   req_valid/req_data/req_last  requester byte offer, requester 0 in the LSBs
//   req_ready                    per-requester accept (valid && ready)
//   tx_data/tx_start/tx_busy     uart_tx byte, start pulse and busy handshake
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one debug UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin grant held for a whole packet; bytes are paced into uart_tx's start/busy port.
//   clk, rst_n          system clock, asynchronous active-low reset
//   bus (slave)         requester handshake and uart_tx port (see uart_tx_arbiter_if)
//   grant_id, active    current owner and packet-grant-held flag
//   timeout             one-cycle pulse when a stalled owner's grant is revoked
//   led_r/led_g/led_b   active-low owner indicator (owner 0/1/2), all high when idle
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BUSY_WAIT      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       grant_id,
  output logic             active,
  output logic             timeout,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > BUSY_WAIT) ? TIMEOUT_CYCLES : BUSY_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0]  LAST_ID = 2'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         rr_q, rr_d;
  logic               active_q, active_d;
  logic               timeout_q, timeout_d;
  logic               last_q, last_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2:0]         led_q, led_d;

  logic               own_valid, own_last;
  logic [7:0]         own_data;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               accept;
  logic               pick_found, hi_found;
  logic [1:0]         pick_idx, hi_idx, lo_idx;
  logic [1:0]         rr_next;

  // Select the current owner's byte, last flag and valid.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == 2'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Only the owner's ready bit can rise, and only in SEND with the uart idle.
  always_comb begin
    req_ready_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_c[i] = (state_q == S_SEND) && (grant_q == 2'(i)) &&
                       bus.req_valid[i] && !bus.tx_busy;
    end
  end

  assign accept = |req_ready_c;

  // Round-robin pick: lowest valid index >= rr pointer, else lowest valid index (wrap).
  always_comb begin
    pick_found = 1'b0;
    hi_found   = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        pick_found = 1'b1;
        lo_idx     = 2'(i);
        if (2'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = 2'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  assign rr_next = (grant_q == LAST_ID) ? 2'd0 : grant_q + 2'd1;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    active_d  = active_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (accept) begin
          tx_data_d = own_data;
          last_d    = own_last;
          cnt_d     = '0;
          state_d   = S_START;
        end else if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
          // Owner stalled too long: revoke and move fairness past it.
          timeout_d = 1'b1;
          active_d  = 1'b0;
          rr_d      = rr_next;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A fast uart may never show busy; give up waiting after BUSY_WAIT cycles.
        if (bus.tx_busy || (cnt_inc >= CNT_W'(BUSY_WAIT))) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_d = '0;
          if (last_q) begin
            active_d = 1'b0;
            rr_d     = rr_next;
            state_d  = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase

    tx_start_d = (state_d == S_START);

    for (int x = 0; x < 3; x++) begin
      led_d[x] = !(active_d && (x < int'(NUM_REQ)) && (grant_d == 2'(x)));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      led_q      <= 3'b111;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      active_q   <= active_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign grant_id      = grant_q;
  assign active        = active_q;
  assign timeout       = timeout_q;
  assign led_r         = led_q[0];
  assign led_g         = led_q[1];
  assign led_b         = led_q[2];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a uart busy model and a
// packet-level round-robin reference model for the randomized traffic.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int T  = 40;
  localparam int BW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       active, timeout, led_r, led_g, led_b;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(T), .BUSY_WAIT(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .active(active), .timeout(timeout),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always #5 clk = ~clk;

  // Requester byte storage
  logic [7:0] mem   [N][64];
  bit         lastm [N][64];
  int         len [N];
  int         pos [N];
  int         stall_at [N];

  // uart model
  int busy_cnt, busy_len;
  bit busy_rand;

  // Observation
  int         cyc;
  logic [N-1:0] rdy_s;
  logic       start_s;
  logic [7:0] obs_data[$];
  logic [1:0] obs_gid[$];
  logic [2:0] obs_led[$];
  logic       obs_act[$];
  int         obs_cyc[$];
  int         to_cnt, to_cyc, first_rdy_cyc, bad_rdy;
  logic       to_act;

  int n_chk = 0;
  int n_fail = 0;

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      len[i] = 0; pos[i] = 0; stall_at[i] = 999;
    end
    busy_cnt = 0; busy_len = 6; busy_rand = 0;
    rdy_s = '0; start_s = 1'b0;
    obs_data.delete(); obs_gid.delete(); obs_led.delete(); obs_act.delete(); obs_cyc.delete();
    to_cnt = 0; to_cyc = -1; to_act = 1'bx; first_rdy_cyc = -1; bad_rdy = 0;
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input bit l);
    mem[i][len[i]] = d;
    lastm[i][len[i]] = l;
    len[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pos[i] < len[i] && pos[i] < stall_at[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = mem[i][pos[i]];
        bus.req_last[i]         = lastm[i][pos[i]];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'($urandom);
        bus.req_last[i]         = 1'($urandom);
      end
    end
    bus.tx_busy = (busy_cnt > 0);
  endtask

  // One clock: apply last cycle's handshakes, run uart model, drive, sample at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (rdy_s[i]) pos[i]++;
    if (start_s) busy_cnt = busy_rand ? int'($urandom_range(0, 8)) : busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    drive();
    @(negedge clk);
    rdy_s   = bus.req_ready;
    start_s = bus.tx_start;
    if (start_s) begin
      obs_data.push_back(bus.tx_data);
      obs_gid.push_back(grant_id);
      obs_led.push_back({led_b, led_g, led_r});
      obs_act.push_back(active);
      obs_cyc.push_back(cyc);
    end
    if (timeout) begin
      to_cnt++; to_cyc = cyc; to_act = active;
    end
    if (rdy_s != '0 && first_rdy_cyc < 0) first_rdy_cyc = cyc;
    if ($countones(rdy_s) > 1 || (rdy_s & ~bus.req_valid) != '0) bad_rdy++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_tb();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_data.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (obs_data.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_tb();
    bus.req_valid = '1;
    bus.req_data  = 24'hA5C3E1;
    bus.req_last  = '1;
    bus.tx_busy   = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
    n_chk++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
    n_chk++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    n_chk++; if (active !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_active_timeout got %b%b want 00", active, timeout); end
    n_chk++; if ({led_b, led_g, led_r} !== 3'b111) begin n_fail++; $display("FAIL reset_leds got %b want 111", {led_b, led_g, led_r}); end
    rst_n = 1'b1;
    clear_tb();
    drive();
    repeat (5) step();
    n_chk++; if (active !== 1'b0 || obs_data.size() != 0) begin n_fail++; $display("FAIL idle_no_req active=%b starts=%0d want 0/0", active, obs_data.size()); end
  endtask

  task automatic test_hi_packet();
    logic [7:0] exp_d [3];
    int en_cyc;
    bit ok;
    exp_d[0] = 8'h48; exp_d[1] = 8'h69; exp_d[2] = 8'h0A;
    apply_reset();
    for (int b = 0; b < 3; b++) add_byte(0, exp_d[b], b == 2);
    step();
    en_cyc = cyc;
    wait_starts(3, 300, ok);
    repeat (20) step();
    n_chk++; if (!ok || obs_data.size() != 3) begin n_fail++; $display("FAIL hi_count got %0d want 3", obs_data.size()); end
    for (int b = 0; b < 3 && b < obs_data.size(); b++) begin
      n_chk++; if (obs_data[b] !== exp_d[b] || obs_gid[b] !== 2'd0) begin n_fail++; $display("FAIL hi_byte[%0d] got %h/g%0d want %h/g0", b, obs_data[b], obs_gid[b], exp_d[b]); end
      n_chk++; if (obs_led[b] !== 3'b110 || obs_act[b] !== 1'b1) begin n_fail++; $display("FAIL hi_led[%0d] got %b act=%b want 110 act=1", b, obs_led[b], obs_act[b]); end
    end
    n_chk++; if (first_rdy_cyc != en_cyc + 1) begin n_fail++; $display("FAIL hi_ready_latency got %0d want %0d", first_rdy_cyc - en_cyc, 1); end
    n_chk++; if (obs_cyc.size() == 0 || obs_cyc[0] != en_cyc + 2) begin n_fail++; $display("FAIL hi_start_latency got %0d want 2", obs_cyc.size() ? obs_cyc[0] - en_cyc : -1); end
    n_chk++; if (active !== 1'b0 || {led_b, led_g, led_r} !== 3'b111) begin n_fail++; $display("FAIL hi_release act=%b leds=%b want 0/111", active, {led_b, led_g, led_r}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [5];
    logic [1:0] exp_g [5];
    bit ok;
    exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h40; exp_d[4] = 8'h42;
    exp_g[0] = 2'd0;  exp_g[1] = 2'd1;  exp_g[2] = 2'd2;  exp_g[3] = 2'd0;  exp_g[4] = 2'd2;
    apply_reset();
    add_byte(0, 8'h10, 1); add_byte(1, 8'h21, 1); add_byte(2, 8'h32, 1);
    wait_starts(3, 300, ok);
    repeat (30) step();
    add_byte(2, 8'h42, 1); add_byte(0, 8'h40, 1);
    wait_starts(5, 300, ok);
    repeat (20) step();
    n_chk++; if (!ok || obs_data.size() != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", obs_data.size()); end
    for (int b = 0; b < 5 && b < obs_data.size(); b++) begin
      n_chk++; if (obs_gid[b] !== exp_g[b] || obs_data[b] !== exp_d[b]) begin n_fail++; $display("FAIL rr_grant[%0d] got g%0d/%h want g%0d/%h", b, obs_gid[b], obs_data[b], exp_g[b], exp_d[b]); end
      n_chk++; if (obs_led[b] !== (3'b111 ^ (3'b001 << exp_g[b]))) begin n_fail++; $display("FAIL rr_led[%0d] got %b want %b", b, obs_led[b], 3'b111 ^ (3'b001 << exp_g[b])); end
    end
    n_chk++; if (bad_rdy != 0) begin n_fail++; $display("FAIL rr_ready_onehot got %0d bad cycles want 0", bad_rdy); end
  endtask

  task automatic test_mid_packet();
    logic [7:0] exp_d [5];
    logic [1:0] exp_g [5];
    int viol, k;
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hA4; exp_d[4] = 8'hB0;
    exp_g[0] = 2'd1;  exp_g[1] = 2'd1;  exp_g[2] = 2'd1;  exp_g[3] = 2'd1;  exp_g[4] = 2'd0;
    apply_reset();
    for (int b = 0; b < 4; b++) add_byte(1, exp_d[b], b == 3);
    add_byte(0, 8'hB0, 1);
    stall_at[0] = 0;
    viol = 0;
    k = 0;
    while (obs_data.size() < 5 && k < 600) begin
      step();
      k++;
      if (pos[1] >= 2) stall_at[0] = 999;
      if (rdy_s[0] && pos[1] < 4) viol++;
    end
    repeat (20) step();
    n_chk++; if (obs_data.size() != 5) begin n_fail++; $display("FAIL mid_count got %0d want 5", obs_data.size()); end
    for (int b = 0; b < 5 && b < obs_data.size(); b++) begin
      n_chk++; if (obs_gid[b] !== exp_g[b] || obs_data[b] !== exp_d[b]) begin n_fail++; $display("FAIL mid_byte[%0d] got g%0d/%h want g%0d/%h", b, obs_gid[b], obs_data[b], exp_g[b], exp_d[b]); end
    end
    n_chk++; if (viol != 0 || bad_rdy != 0) begin n_fail++; $display("FAIL mid_nonowner_ready got %0d/%0d want 0/0", viol, bad_rdy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    apply_reset();
    busy_len = 3;
    add_byte(0, 8'h11, 0); add_byte(0, 8'h22, 1);
    add_byte(1, 8'h33, 1);
    stall_at[0] = 1;
    k = 0;
    while (to_cnt == 0 && k < 400) begin step(); k++; end
    n_chk++; if (to_cnt == 0) begin n_fail++; $display("FAIL to_seen got none want pulse within 400 cycles"); end
    stall_at[0] = 999;
    wait_starts(3, 400, ok);
    repeat (30) step();
    n_chk++; if (to_cnt != 1) begin n_fail++; $display("FAIL to_pulse_count got %0d want 1", to_cnt); end
    n_chk++; if (to_act !== 1'b0) begin n_fail++; $display("FAIL to_active got %b want 0", to_act); end
    n_chk++; if (obs_cyc.size() == 0 || to_cyc - obs_cyc[0] != T + busy_len + 2) begin n_fail++; $display("FAIL to_delay got %0d want %0d", obs_cyc.size() ? to_cyc - obs_cyc[0] : -1, T + busy_len + 2); end
    n_chk++; if (!ok || obs_data.size() != 3) begin n_fail++; $display("FAIL to_count got %0d want 3", obs_data.size()); end
    if (obs_data.size() >= 3) begin
      n_chk++; if (obs_data[0] !== 8'h11 || obs_gid[0] !== 2'd0) begin n_fail++; $display("FAIL to_first got g%0d/%h want g0/11", obs_gid[0], obs_data[0]); end
      n_chk++; if (obs_data[1] !== 8'h33 || obs_gid[1] !== 2'd1 || obs_cyc[1] <= to_cyc) begin n_fail++; $display("FAIL to_next_owner got g%0d/%h want g1/33 after timeout", obs_gid[1], obs_data[1]); end
      n_chk++; if (obs_data[2] !== 8'h22 || obs_gid[2] !== 2'd0) begin n_fail++; $display("FAIL to_resume got g%0d/%h want g0/22", obs_gid[2], obs_data[2]); end
    end
  endtask

  task automatic test_no_busy();
    logic [7:0] exp_d [5];
    logic [1:0] exp_g [5];
    bit ok;
    int mingap;
    exp_d[0] = 8'hC0; exp_d[1] = 8'hC1; exp_d[2] = 8'hE0; exp_d[3] = 8'hE1; exp_d[4] = 8'hE2;
    exp_g[0] = 2'd0;  exp_g[1] = 2'd0;  exp_g[2] = 2'd2;  exp_g[3] = 2'd2;  exp_g[4] = 2'd2;
    apply_reset();
    busy_len = 0;
    for (int b = 2; b < 5; b++) add_byte(2, exp_d[b], b == 4);
    add_byte(0, 8'hC0, 0); add_byte(0, 8'hC1, 1);
    wait_starts(5, 400, ok);
    repeat (30) step();
    n_chk++; if (!ok || obs_data.size() != 5) begin n_fail++; $display("FAIL nobusy_count got %0d want 5", obs_data.size()); end
    for (int b = 0; b < 5 && b < obs_data.size(); b++) begin
      n_chk++; if (obs_gid[b] !== exp_g[b] || obs_data[b] !== exp_d[b]) begin n_fail++; $display("FAIL nobusy_byte[%0d] got g%0d/%h want g%0d/%h", b, obs_gid[b], obs_data[b], exp_g[b], exp_d[b]); end
    end
    mingap = 1000;
    for (int b = 1; b < obs_cyc.size(); b++) if (obs_cyc[b] - obs_cyc[b-1] < mingap) mingap = obs_cyc[b] - obs_cyc[b-1];
    n_chk++; if (mingap < BW + 2) begin n_fail++; $display("FAIL nobusy_start_gap got %0d want >= %0d", mingap, BW + 2); end
  endtask

  task automatic test_reset_wait_done();
    bit ok;
    apply_reset();
    busy_len = 20;
    add_byte(1, 8'h5A, 0); add_byte(1, 8'hA5, 1);
    wait_starts(1, 100, ok);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL arst_tx got %h/%b want 00/0", bus.tx_data, bus.tx_start); end
    n_chk++; if (active !== 1'b0 || grant_id !== 2'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl got act=%b g=%0d to=%b want 0/0/0", active, grant_id, timeout); end
    n_chk++; if ({led_b, led_g, led_r} !== 3'b111 || bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL arst_led_ready got %b/%b want 111/000", {led_b, led_g, led_r}, bus.req_ready); end
    clear_tb();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    add_byte(2, 8'h77, 1); add_byte(0, 8'h66, 1);
    wait_starts(2, 200, ok);
    repeat (30) step();
    n_chk++; if (!ok || obs_data.size() != 2) begin n_fail++; $display("FAIL arst_after_count got %0d want 2", obs_data.size()); end
    if (obs_data.size() >= 2) begin
      n_chk++; if (obs_gid[0] !== 2'd0 || obs_data[0] !== 8'h66 || obs_gid[1] !== 2'd2 || obs_data[1] !== 8'h77) begin n_fail++; $display("FAIL arst_rr0 got g%0d/%h,g%0d/%h want g0/66,g2/77", obs_gid[0], obs_data[0], obs_gid[1], obs_data[1]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    logic [1:0] exp_g[$];
    int ptr [N];
    int rr_m, npk, nb, g, errs;
    bit ok;
    apply_reset();
    busy_rand = 1;
    rr_m = 0;
    errs = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        ptr[i] = len[i];
        npk = int'($urandom_range(0, 2));
        if (i == r % N && npk == 0) npk = 1;
        for (int p = 0; p < npk; p++) begin
          nb = int'($urandom_range(1, 4));
          for (int b = 0; b < nb; b++) add_byte(i, 8'($urandom), b == nb - 1);
        end
      end
      // Packet-level model: whole packets, owner chosen round-robin from the pointer.
      while (1) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          if (g < 0 && ptr[(rr_m + k) % N] < len[(rr_m + k) % N]) g = (rr_m + k) % N;
        end
        if (g < 0) break;
        do begin
          exp_d.push_back(mem[g][ptr[g]]);
          exp_g.push_back(2'(g));
          ptr[g]++;
        end while (!lastm[g][ptr[g] - 1]);
        rr_m = (g + 1) % N;
      end
      wait_starts(exp_d.size(), 4000, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand_round%0d_progress got %0d starts want %0d", r, obs_data.size(), exp_d.size()); end
    end
    repeat (30) step();
    n_chk++; if (obs_data.size() != exp_d.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_data.size(), exp_d.size()); end
    for (int b = 0; b < exp_d.size() && b < obs_data.size(); b++) begin
      n_chk++;
      if (obs_data[b] !== exp_d[b] || obs_gid[b] !== exp_g[b]) begin
        n_fail++; errs++;
        if (errs < 8) $display("FAIL rand_byte[%0d] got g%0d/%h want g%0d/%h", b, obs_gid[b], obs_data[b], exp_g[b], exp_d[b]);
      end
    end
    n_chk++; if (bad_rdy != 0 || to_cnt != 0) begin n_fail++; $display("FAIL rand_ready_timeout got %0d/%0d want 0/0", bad_rdy, to_cnt); end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_hi_packet();
    test_round_robin();
    test_mid_packet();
    test_timeout();
    test_no_busy();
    test_reset_wait_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
